// File: rtl/fd_ctrl_pkg.sv
// Shared types and constants for the fetch/decode control unit.
package fd_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    // Control sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // funct3 / funct7 values of the supported subset
    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_DWORD  = 3'b011;
    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;

    // Datapath operation select
    localparam logic [1:0] OP_RR = 2'b00;
    localparam logic [1:0] OP_RI = 2'b01;
    localparam logic [1:0] OP_LD = 2'b10;
    localparam logic [1:0] OP_SD = 2'b11;

    // Decoded control bundle
    typedef struct packed {
        logic       valid;
        logic       is_zero;
        logic [1:0] op_mem_i;
        logic       add_sub;
        logic       we_reg;
        logic       we_mem;
    } dec_t;

endpackage

// File: rtl/fd_decoder.sv
// Combinational instruction decoder for the supported ADD/SUB/ADDI/LD/SD subset.
module fd_decoder
    import fd_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] ir,
    output dec_t            dec_c
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       rd_nz;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign rd_nz  = (ir[11:7] != 5'd0);

    // Map instruction fields to datapath controls; writes to x0 are dropped here
    always_comb begin
        dec_c         = '0;
        dec_c.is_zero = (ir == '0);
        case (opcode)
            OPC_OP: begin
                if (funct3 == F3_ADD && funct7 == F7_ADD) begin
                    dec_c.valid    = 1'b1;
                    dec_c.op_mem_i = OP_RR;
                    dec_c.we_reg   = rd_nz;
                end else if (funct3 == F3_ADD && funct7 == F7_SUB) begin
                    dec_c.valid    = 1'b1;
                    dec_c.op_mem_i = OP_RR;
                    dec_c.add_sub  = 1'b1;
                    dec_c.we_reg   = rd_nz;
                end
            end
            OPC_OP_IMM: begin
                if (funct3 == F3_ADD) begin
                    dec_c.valid    = 1'b1;
                    dec_c.op_mem_i = OP_RI;
                    dec_c.we_reg   = rd_nz;
                end
            end
            OPC_LOAD: begin
                if (funct3 == F3_DWORD) begin
                    dec_c.valid    = 1'b1;
                    dec_c.op_mem_i = OP_LD;
                    dec_c.we_reg   = rd_nz;
                end
            end
            OPC_STORE: begin
                if (funct3 == F3_DWORD) begin
                    dec_c.valid    = 1'b1;
                    dec_c.op_mem_i = OP_SD;
                    dec_c.we_mem   = 1'b1;
                end
            end
            default: dec_c.valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/fd_control_unit.sv
// Four-cycle multicycle sequencer for the fetch/decode datapath.
module fd_control_unit
    import fd_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [XLEN-1:0]   instruction,
    output logic [XLEN-1:0]   PC_add,
    output logic              PC_load,
    output logic [1:0]        OP_MEM_I,
    output logic              ADD_SUB,
    output logic              WE_reg,
    output logic              WE_mem,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [CNT_W-1:0]  instr_count
);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   ir_q, ir_next;
    logic              stop_pend_q, stop_pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              illegal_q, illegal_d;
    dec_t              dec;
    logic              exec_wb_d;

    // Instruction is captured while leaving DECODE, so decode the value about to be held
    assign ir_next = (state_q == DECODE) ? instruction : ir_q;

    fd_decoder u_decoder (
        .ir    (ir_next),
        .dec_c (dec)
    );

    // Next-state and architectural-register update logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        stop_pend_d = stop_pend_q;
        cnt_d       = cnt_q;
        illegal_d   = illegal_q;
        unique case (state_q)
            IDLE, HALT: begin
                if (start && !stop) begin
                    state_d   = FETCH;
                    pc_d      = RESET_PC;
                    cnt_d     = '0;
                    illegal_d = 1'b0;
                end
            end
            FETCH: begin
                state_d = DECODE;
                if (stop) stop_pend_d = 1'b1;
            end
            DECODE: begin
                if (stop) stop_pend_d = 1'b1;
                if (dec.valid) begin
                    state_d = EXEC;
                end else begin
                    state_d   = HALT;
                    illegal_d = !dec.is_zero;
                end
            end
            EXEC: begin
                state_d = WB;
                if (stop) stop_pend_d = 1'b1;
            end
            WB: begin
                pc_d  = pc_q + XLEN'(PC_STEP);
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                if (stop_pend_q || stop) state_d = HALT;
                else                     state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == HALT) stop_pend_d = 1'b0;
    end

    assign exec_wb_d = (state_d == EXEC) || (state_d == WB);

    // State and architectural registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            stop_pend_q <= 1'b0;
            cnt_q       <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_next;
            stop_pend_q <= stop_pend_d;
            cnt_q       <= cnt_d;
            illegal_q   <= illegal_d;
        end
    end

    // Registered control outputs, computed from the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC_load  <= 1'b0;
            OP_MEM_I <= OP_RR;
            ADD_SUB  <= 1'b0;
            WE_reg   <= 1'b0;
            WE_mem   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            PC_load  <= (state_d == FETCH);
            OP_MEM_I <= exec_wb_d ? dec.op_mem_i : OP_RR;
            ADD_SUB  <= exec_wb_d && dec.add_sub;
            WE_reg   <= (state_d == WB) && dec.we_reg;
            WE_mem   <= (state_d == WB) && dec.we_mem;
            busy     <= (state_d == FETCH) || (state_d == DECODE) || exec_wb_d;
            done     <= (state_d == HALT);
        end
    end

    assign PC_add      = pc_q;
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

endmodule

// File: doc/fd_control_unit.md
# fd_control_unit

Multicycle control FSM that sequences the fetch/decode datapath (PC register, instruction memory, register bank, data memory, adder/subtractor). It owns the program counter value presented on `PC_add` and pulses `PC_load`. It decodes the fetched instruction and drives `OP_MEM_I`, `ADD_SUB`, `WE_reg` and `WE_mem` so that each supported instruction completes in exactly four cycles. It exposes a start/stop/done handshake to the testbench or top level.

## Interface
- `RESET_PC`, default 32'h0000_0000: first instruction address after reset or restart.
- `PC_STEP`, default 4: PC increment per retired instruction.
- `CNT_W`, default 16: width of the retired-instruction counter.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin execution; sampled only in IDLE and HALT.
- `stop`  in  1  request halt at the next instruction boundary.
- `instruction`  in  32  fetched instruction from the datapath.
- `PC_add`  out  32  next PC value fed to the datapath PC register.
- `PC_load`  out  1  PC register load strobe.
- `OP_MEM_I`  out  2  datapath operation select (encodings under Structure).
- `ADD_SUB`  out  1  0 = add, 1 = subtract.
- `WE_reg`  out  1  register bank write strobe.
- `WE_mem`  out  1  data memory write strobe.
- `busy`  out  1  high in FETCH, DECODE, EXEC and WB.
- `done`  out  1  high in HALT.
- `illegal`  out  1  sticky; set when the halt was caused by an unsupported opcode.
- `instr_count`  out  CNT_W  retired instructions; saturates at all-ones.

## Operation
- States: IDLE → FETCH → DECODE → EXEC → WB → FETCH …; HALT.
- IDLE: all strobes 0. If `start`=1, load `pc_q`=RESET_PC, clear `instr_count` and `illegal`, then go to FETCH.
- FETCH: `PC_load`=1 for one cycle, so the datapath PC takes `pc_q`. Then go to DECODE.
- DECODE: capture `instruction` into `ir`.
  - Supported `ir`: go to EXEC.
  - `ir`=0 (end of program): go to HALT with `illegal`=0.
  - Any other unsupported encoding: go to HALT with `illegal`=1.
- Supported instructions (opcode/funct3/funct7):
  - ADD: 0110011/000/0000000 → OP_RR, `ADD_SUB`=0.
  - SUB: 0110011/000/0100000 → OP_RR, `ADD_SUB`=1.
  - ADDI: 0010011/000 → OP_RI, `ADD_SUB`=0.
  - LD: 0000011/011 → OP_LD, `ADD_SUB`=0.
  - SD: 0100011/011 → OP_SD, `ADD_SUB`=0.
- EXEC: `OP_MEM_I` and `ADD_SUB` are driven from `ir`. They hold unchanged through WB and are 0 in every other state.
- WB:
  - ADD, SUB, ADDI, LD: `WE_reg`=1, except when `ir[11:7]`=0 (writes to x0 are suppressed).
  - SD: `WE_mem`=1.
  - In all cases, `pc_q` += PC_STEP (32-bit wrap) and `instr_count` increments (saturating).
  - Next state is HALT if a stop request is pending, else FETCH.
- `stop` is latched into `stop_pend` in any busy state and cleared on entry to HALT. In IDLE, `stop` wins over a simultaneous `start`; the block stays in IDLE.
- HALT: `done`=1. `start` restarts exactly as from IDLE.
- `PC_add` = `pc_q` at all times.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, `pc_q` = RESET_PC, `ir`=0, `stop_pend`=0, `instr_count`=0, `illegal`=0.
  - All strobes, `busy` and `done` = 0.
- Latency: `start` at edge N → `PC_load` high in cycle N+1. Each instruction takes exactly 4 cycles; the FETCH of instruction k+1 follows the WB of instruction k.
- `WE_reg` and `WE_mem` are single-cycle pulses, never asserted together, and only in WB.
- Reset asserted mid-instruction: strobes drop immediately; no partial write may follow.
- `pc_q` at 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- `instr_count` holds at 2^CNT_W−1 once saturated.

## Structure
- Package `fd_ctrl_pkg`:
  - state enum: IDLE, FETCH, DECODE, EXEC, WB, HALT.
  - opcode constants.
  - `OP_MEM_I` encodings: OP_RR=2'b00, OP_RI=2'b01, OP_LD=2'b10, OP_SD=2'b11.
- One sub-module, `fd_decoder`: combinational map `ir` → {valid, is_zero, op_mem_i, add_sub, we_reg, we_mem}. The FSM remains in `fd_control_unit`.

## Test plan
- Reset with RESET_PC=0; pulse `start`.
  - `PC_load` pulses every 4 cycles with `PC_add` = 0, 4, 8.
  - `busy`=1 throughout.
- Program ADDI x1,x0,5; ADDI x2,x0,3; SUB x3,x1,x2; then 0.
  - In WB of SUB: `ADD_SUB`=1, `WE_reg`=1.
  - Then `done`=1, `illegal`=0, `instr_count`=3.
- SD x1,8(x0) then LD x4,8(x0).
  - Exactly one `WE_mem` pulse, then one `WE_reg` pulse with `OP_MEM_I`=2'b10.
- ADDI x0,x0,7.
  - No `WE_reg` pulse; `PC_add` still advances by 4.
- Opcode 1111111 at PC 12.
  - HALT from DECODE, `illegal`=1, `instr_count`=3, no strobes.
- Boundary and reset cases:
  - `stop` asserted during EXEC of the 2nd instruction: it retires, then HALT, `instr_count`=2.
  - `reset` asserted during WB: all outputs 0 in the same cycle.
